// File: rtl/avalon_path_fifo.sv
// Avalon-MM slave that queues path words from the processor and streams them to a valid/ready consumer.
// Optional feature macro: AVALON_PATH_FIFO_IRQ_EN adds the addr3 thresh register and the low-watermark irq output.
module avalon_path_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef AVALON_PATH_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enable_q, enable_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      popCnt_q, popCnt_d;
`ifdef AVALON_PATH_FIFO_IRQ_EN
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             irq_q;
`endif

  logic wr, pushReq, ctrlWr, flush, full, empty, pop, push, ovfEvt;

  assign wr      = chipselect && !write_n;
  assign pushReq = wr && (address == 2'd0);
  assign ctrlWr  = wr && (address == 2'd1);
  assign flush   = ctrlWr && writedata[1];
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);

  assign out_valid = enable_q && !empty;
  assign out_data  = out_valid ? mem[rdPtr_q] : '0;
  assign pop       = out_valid && out_ready;

  // A flush swallows any same-cycle push silently; only a genuine full-drop flags overflow.
  assign push   = pushReq && (!full || pop) && !flush;
  assign ovfEvt = pushReq && full && !pop && !flush;

  always_comb begin
    count_d    = count_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;
    popCnt_d   = popCnt_q;
`ifdef AVALON_PATH_FIFO_IRQ_EN
    thresh_d   = thresh_q;
`endif

    if (flush) begin
      count_d = '0;
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    if (ctrlWr) enable_d = writedata[0];

    // Set has priority over the write-one-to-clear.
    if (ovfEvt)                      overflow_d = 1'b1;
    else if (ctrlWr && writedata[2]) overflow_d = 1'b0;

    if (wr && (address == 2'd2)) popCnt_d = '0;
    else if (pop)                popCnt_d = popCnt_q + 32'd1;

`ifdef AVALON_PATH_FIFO_IRQ_EN
    if (wr && (address == 2'd3)) thresh_d = writedata[CNT_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      popCnt_q   <= '0;
`ifdef AVALON_PATH_FIFO_IRQ_EN
      thresh_q   <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      popCnt_q   <= popCnt_d;
`ifdef AVALON_PATH_FIFO_IRQ_EN
      thresh_q   <= thresh_d;
      irq_q      <= enable_q && (count_q <= thresh_q);
`endif
    end
  end

  // Storage is not reset; stale words are unreachable once count and pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= writedata[DATA_W-1:0];
  end

`ifdef AVALON_PATH_FIFO_IRQ_EN
  assign irq = irq_q;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'(out_data);
      2'd1: begin
        readdata[CNT_W-1:0] = count_q;
        readdata[16]        = empty;
        readdata[17]        = full;
        readdata[18]        = overflow_q;
        readdata[19]        = enable_q;
      end
      2'd2: readdata = popCnt_q;
`ifdef AVALON_PATH_FIFO_IRQ_EN
      2'd3: readdata[CNT_W-1:0] = thresh_q;
`endif
      default: readdata = '0;
    endcase
  end

endmodule
